// File: rtl/mem_latency_server.sv
// Fixed-latency memory responder: word storage, strobed writes, backdoor init port,
// and an in-order outstanding queue whose head answers once its countdown expires.
module mem_latency_server #(
    parameter int p_opaq_bits = 8,
    parameter int p_num_words = 256,
    parameter int p_latency   = 2,
    parameter int p_depth     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_op,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    input  logic [3:0]             req_strb,
    input  logic [p_opaq_bits-1:0] req_opaque,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_op,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data,
    output logic [p_opaq_bits-1:0] resp_opaque,
    input  logic                   init_en,
    input  logic [31:0]            init_addr,
    input  logic [31:0]            init_data
);
    localparam int WI = $clog2(p_num_words);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int NW = $clog2(p_depth + 1);
    localparam int CW = (p_latency > 1) ? $clog2(p_latency) : 1;

    typedef struct packed {
        logic                   op;
        logic [31:0]            addr;
        logic [31:0]            data;
        logic [p_opaq_bits-1:0] opaque;
    } ent_t;

    logic [31:0]     mem_q [p_num_words];
    ent_t            ent_q [p_depth];
    logic [CW-1:0]   cnt_q [p_depth];
    logic [p_depth-1:0] vld_q;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [NW-1:0]   count_q, count_d;

    logic [WI-1:0]   req_idx, init_idx;
    logic            req_fire, resp_fire;
    logic            unused_ok;

    assign req_idx   = req_addr[WI+1:2];
    assign init_idx  = init_addr[WI+1:2];
    assign unused_ok = ^{init_addr[31:WI+2], init_addr[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on occupancy (and reset), never on resp_rdy.
    assign req_rdy   = rst && (count_q < NW'(p_depth));
    assign resp_val  = (count_q != '0) && (cnt_q[head_q] == '0);
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;

    assign resp_op     = resp_val ? ent_q[head_q].op     : 1'b0;
    assign resp_addr   = resp_val ? ent_q[head_q].addr   : '0;
    assign resp_data   = resp_val ? ent_q[head_q].data   : '0;
    assign resp_opaque = resp_val ? ent_q[head_q].opaque : '0;

    always_comb begin
        head_d  = resp_fire ? ptr_inc(head_q) : head_q;
        tail_d  = req_fire  ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + NW'(req_fire) - NW'(resp_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < p_depth; i++)
                if (vld_q[i] && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - CW'(1);
            if (resp_fire)
                vld_q[head_q] <= 1'b0;
            // Read data is captured from the pre-edge array contents.
            if (req_fire) begin
                ent_q[tail_q].op     <= req_op;
                ent_q[tail_q].addr   <= req_addr;
                ent_q[tail_q].data   <= req_op ? 32'h0 : mem_q[req_idx];
                ent_q[tail_q].opaque <= req_opaque;
                cnt_q[tail_q]        <= CW'(p_latency - 1);
                vld_q[tail_q]        <= 1'b1;
            end
        end
    end

    // Storage is never reset; the init write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (req_fire && req_op)
            for (int b = 0; b < 4; b++)
                if (req_strb[b])
                    mem_q[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        if (init_en)
            mem_q[init_idx] <= init_data;
    end
endmodule
